// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary encoder.
package unary_pkg;

  localparam int unsigned DefaultW = 16;

  // Width of the binary count: wide enough to hold W itself and out-of-range values.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  typedef struct packed {
    logic sat;
    logic compliment;
  } unary_ctl_t;

endpackage

// File: rtl/unary_enc_if.sv
// Count-in / code-out handshake bundle for unary_enc.
// Signal names are written from the encoder's side (i_* into it, o_* out of it).
interface unary_enc_if
  import unary_pkg::*;
#(
  parameter int unsigned W = DefaultW
) ();

  localparam int unsigned CW = cnt_w(W);

  logic          i_vld;
  logic          o_rdy;
  logic [CW-1:0] i_cnt;
  logic          i_compliment;
  logic          o_vld;
  logic          i_rdy;
  logic [W-1:0]  o_x;
  logic          o_is_compliment;
  logic          o_sat;

  // Environment side: produces counts, consumes codes.
  modport master (
    output i_vld, i_cnt, i_compliment, i_rdy,
    input  o_rdy, o_vld, o_x, o_is_compliment, o_sat
  );

  // Encoder side.
  modport slave (
    input  i_vld, i_cnt, i_compliment, i_rdy,
    output o_rdy, o_vld, o_x, o_is_compliment, o_sat
  );

endinterface

// File: rtl/unary_enc_dec.sv
// Combinational thermometer decoder: bit j set when j < n, optionally inverted.
// Inversion exists only when UNARY_ENC_COMPLIMENT_EN is defined.
module unary_enc_dec
  import unary_pkg::*;
#(
  parameter int unsigned W  = DefaultW,
  localparam int unsigned CW = cnt_w(W)
) (
  input  logic [CW-1:0] n_i,
  input  logic          compliment_i,
  output logic [W-1:0]  x_o
);

  logic [W-1:0] thermo;

  // One comparator per code bit.
  always_comb begin
    thermo = '0;
    for (int unsigned j = 0; j < W; j++) begin
      thermo[j] = CW'(j) < n_i;
    end
  end

`ifdef UNARY_ENC_COMPLIMENT_EN
  assign x_o = compliment_i ? ~thermo : thermo;
`else
  logic unused_compliment;
  assign unused_compliment = compliment_i;
  assign x_o = thermo;
`endif

endmodule

// File: rtl/unary_enc.sv
// Streaming binary-to-unary encoder, 2-stage stallable valid/ready pipeline.
// S1 captures the (saturated) count, S2 holds the decoded code.
// Optional complement form: define UNARY_ENC_COMPLIMENT_EN.
module unary_enc
  import unary_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input logic        i_clk,
  input logic        i_arst_n,
  unary_enc_if.slave bus
);

  localparam int unsigned   CW   = cnt_w(W);
  localparam logic [CW-1:0] WCnt = CW'(W);
  localparam logic [CW-1:0] MaxN = CW'(W - 1);

  logic          s1_adv;
  logic          accept;
  logic          in_comp;

  logic          s1_vld_q, s1_vld_d;
  logic [CW-1:0] s1_n_q, s1_n_d;
  unary_ctl_t    s1_ctl_q, s1_ctl_d;

  logic          s2_vld_q, s2_vld_d;
  logic [W-1:0]  s2_x_q, s2_x_d;
  unary_ctl_t    s2_ctl_q, s2_ctl_d;

  logic [W-1:0]  dec_x;

`ifdef UNARY_ENC_COMPLIMENT_EN
  assign in_comp             = bus.i_compliment;
  assign bus.o_is_compliment = s2_ctl_q.compliment;
`else
  logic unused_compliment;
  assign unused_compliment   = ^{bus.i_compliment, s2_ctl_q.compliment};
  assign in_comp             = 1'b0;
  assign bus.o_is_compliment = 1'b0;
`endif

  // S1 may move on when S2 is empty or draining; ready never depends on i_vld.
  assign s1_adv    = ~s2_vld_q | bus.i_rdy;
  assign bus.o_rdy = ~s1_vld_q | s1_adv;
  assign accept    = bus.i_vld & bus.o_rdy;

  // S1 next state: capture count with saturation on accept.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_n_d   = s1_n_q;
    s1_ctl_d = s1_ctl_q;
    if (bus.o_rdy) begin
      s1_vld_d = bus.i_vld;
    end
    if (accept) begin
      s1_ctl_d.sat        = (bus.i_cnt >= WCnt);
      s1_ctl_d.compliment = in_comp;
      s1_n_d              = s1_ctl_d.sat ? MaxN : bus.i_cnt;
    end
  end

  unary_enc_dec #(
    .W(W)
  ) u_dec (
    .n_i         (s1_n_q),
    .compliment_i(s1_ctl_q.compliment),
    .x_o         (dec_x)
  );

  // S2 next state: load decoded code from S1, hold while stalled.
  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_x_d   = s2_x_q;
    s2_ctl_d = s2_ctl_q;
    if (s1_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_x_d   = dec_x;
        s2_ctl_d = s1_ctl_q;
      end
    end
  end

  // Pipeline registers; reset discards every in-flight beat.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s1_vld_q <= 1'b0;
      s1_n_q   <= '0;
      s1_ctl_q <= '0;
      s2_vld_q <= 1'b0;
      s2_x_q   <= '0;
      s2_ctl_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_n_q   <= s1_n_d;
      s1_ctl_q <= s1_ctl_d;
      s2_vld_q <= s2_vld_d;
      s2_x_q   <= s2_x_d;
      s2_ctl_q <= s2_ctl_d;
    end
  end

  assign bus.o_vld = s2_vld_q;
  assign bus.o_x   = s2_x_q;
  assign bus.o_sat = s2_ctl_q.sat;

  // Output beat must stay put until the sink takes it.
  a_hold_stall : assert property (@(posedge i_clk) disable iff (!i_arst_n)
    (bus.o_vld && !bus.i_rdy) |=> (bus.o_vld && $stable(bus.o_x) && $stable(bus.o_sat)
                                   && $stable(bus.o_is_compliment)));

endmodule

// File: tb/tb_unary_enc.sv
// Directed bench for unary_enc at W=16.
module tb_unary_enc;
  import unary_pkg::*;

  localparam int unsigned W = 16;
`ifdef UNARY_ENC_COMPLIMENT_EN
  localparam bit CompEn = 1'b1;
`else
  localparam bit CompEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unary_enc_if #(.W(W)) bus ();

  unary_enc #(
    .W(W)
  ) dut (
    .i_clk   (clk),
    .i_arst_n(rst_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic [4:0]  cnt;
    logic        comp;
    logic [15:0] x_plain;
    logic [15:0] x_comp;
    logic        sat;
  } vec_t;

  vec_t vecs[11];

  logic [4:0]  in_q[$];
  logic [15:0] out_q[$];
  int          first_fire;
  int          last_fire;
  bit          saw_rdy_low;

  // Called at posedge+1; advances in whole cycles keeping that phase.
  task automatic idle(input int n);
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single beat with sink always ready; checks latency and the emitted code.
  task automatic send_one(input vec_t v);
    int          lat;
    logic [15:0] ex;
    logic        ec;
    ec = CompEn & v.comp;
    ex = ec ? v.x_comp : v.x_plain;
    bus.i_rdy        = 1'b1;
    bus.i_vld        = 1'b1;
    bus.i_cnt        = v.cnt;
    bus.i_compliment = v.comp;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) bus.i_vld = 1'b0;
    end while (!bus.o_vld && lat < 10);
    check($sformatf("latency cnt=%0d comp=%0d", v.cnt, v.comp), lat, 2);
    check($sformatf("o_x cnt=%0d comp=%0d", v.cnt, v.comp), bus.o_x, ex);
    check($sformatf("o_sat cnt=%0d", v.cnt), bus.o_sat, v.sat);
    check($sformatf("o_is_compliment cnt=%0d comp=%0d", v.cnt, v.comp), bus.o_is_compliment, ec);
    bus.i_compliment = 1'b0;
  endtask

  // Streams in_q with sink readiness rdy_mask[cycle]; collects retired codes in out_q.
  task automatic run_stream(input logic [63:0] rdy_mask, input int max_cycles);
    int          idx;
    int          cyc;
    bit          stall_prev;
    logic [15:0] px;
    logic        psat;
    idx = 0;
    cyc = 0;
    stall_prev = 1'b0;
    px = '0;
    psat = 1'b0;
    out_q.delete();
    first_fire = -1;
    last_fire = -1;
    saw_rdy_low = 1'b0;
    bus.i_compliment = 1'b0;
    while (cyc < max_cycles && out_q.size() < in_q.size()) begin
      if (stall_prev) begin
        check($sformatf("hold o_vld cyc=%0d", cyc), bus.o_vld, 1'b1);
        check($sformatf("hold o_x cyc=%0d", cyc), {bus.o_x, bus.o_sat}, {px, psat});
      end
      bus.i_rdy = rdy_mask[cyc];
      if (idx < in_q.size()) begin
        bus.i_vld = 1'b1;
        bus.i_cnt = in_q[idx];
      end else begin
        bus.i_vld = 1'b0;
      end
      #1;
      if (!bus.o_rdy) saw_rdy_low = 1'b1;
      if (bus.i_vld && bus.o_rdy) idx++;
      if (bus.o_vld && bus.i_rdy) begin
        out_q.push_back(bus.o_x);
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      stall_prev = bus.o_vld && !bus.i_rdy;
      px = bus.o_x;
      psat = bus.o_sat;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b1;
    check("stream beat count", out_q.size(), in_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stale;
    logic [15:0] exp_x;

    vecs[0]  = '{5'd5,  1'b0, 16'h001F, 16'h001F, 1'b0};
    vecs[1]  = '{5'd5,  1'b1, 16'h001F, 16'hFFE0, 1'b0};
    vecs[2]  = '{5'd0,  1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{5'd0,  1'b1, 16'h0000, 16'hFFFF, 1'b0};
    vecs[4]  = '{5'd15, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[5]  = '{5'd20, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[6]  = '{5'd16, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[7]  = '{5'd31, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[8]  = '{5'd1,  1'b0, 16'h0001, 16'h0001, 1'b0};
    vecs[9]  = '{5'd8,  1'b0, 16'h00FF, 16'h00FF, 1'b0};
    vecs[10] = '{5'd14, 1'b1, 16'h3FFF, 16'hC000, 1'b0};

    rst_n = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_cnt = '0;
    bus.i_compliment = 1'b0;
    bus.i_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset o_vld", bus.o_vld, 1'b0);
    check("reset o_x", bus.o_x, 16'h0000);
    check("reset o_sat", bus.o_sat, 1'b0);
    check("reset o_is_compliment", bus.o_is_compliment, 1'b0);
    check("reset o_rdy", bus.o_rdy, 1'b1);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 11; i++) send_one(vecs[i]);

    // Stall mid-stream: sink not ready in cycles 2..4.
    idle(3);
    in_q = '{5'd1, 5'd2, 5'd3, 5'd4};
    run_stream(~64'h1C, 20);
    check("stall o_rdy dropped", saw_rdy_low, 1'b1);
    if (out_q.size() == 4) begin
      check("stall beat0", out_q[0], 16'h0001);
      check("stall beat1", out_q[1], 16'h0003);
      check("stall beat2", out_q[2], 16'h0007);
      check("stall beat3", out_q[3], 16'h000F);
    end

    // Full throughput, 32 counts 0..31.
    idle(3);
    in_q.delete();
    for (int c = 0; c < 32; c++) in_q.push_back(5'(c));
    run_stream('1, 60);
    check("throughput first beat cycle", first_fire, 2);
    check("throughput span", last_fire - first_fire, 31);
    for (int c = 0; c < 32 && c < out_q.size(); c++) begin
      exp_x = (c >= 16) ? 16'h7FFF : 16'((32'd1 << c) - 1);
      check($sformatf("throughput beat %0d", c), out_q[c], exp_x);
    end

    // Async reset with both stages full.
    idle(3);
    bus.i_rdy = 1'b0;
    bus.i_vld = 1'b1;
    bus.i_cnt = 5'd3;
    @(posedge clk);
    #1;
    bus.i_cnt = 5'd7;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    check("full before reset o_vld", bus.o_vld, 1'b1);
    check("full before reset o_rdy", bus.o_rdy, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset o_vld", bus.o_vld, 1'b0);
    check("async reset o_x", bus.o_x, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_rdy = 1'b1;
    stale = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.o_vld) stale++;
    end
    check("no stale beats after reset", stale, 0);
    send_one('{5'd9, 1'b0, 16'h01FF, 16'h01FF, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
